// File: rtl/ahb_slave_req_mux.sv
// rtl/ahb_slave_req_mux.sv - A/B request arbiter, request buffer and write-data steer for one AHB-Lite slave port
// Optional feature macro: AHB_REQ_RR_EN (round-robin priority); undefined gives fixed priority, B over A.
module ahb_slave_req_mux #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              HSEL_A,
   input  logic [ADDR_W-1:0] HADDR_A,
   input  logic [1:0]        HTRANS_A,
   input  logic              HWRITE_A,
   input  logic [2:0]        HSIZE_A,
   input  logic [DATA_W-1:0] HWDATA_A,
   input  logic              HSEL_B,
   input  logic [ADDR_W-1:0] HADDR_B,
   input  logic [1:0]        HTRANS_B,
   input  logic              HWRITE_B,
   input  logic [2:0]        HSIZE_B,
   input  logic [DATA_W-1:0] HWDATA_B,
   input  logic              HREADY_S,
   output logic              HSEL_S,
   output logic [ADDR_W-1:0] HADDR_S,
   output logic [1:0]        HTRANS_S,
   output logic              HWRITE_S,
   output logic [2:0]        HSIZE_S,
   output logic [DATA_W-1:0] HWDATA_S,
   output logic              arbiter_WR,
   output logic              req_wait_A,
   output logic              req_wait_B
);

   localparam logic [1:0] TR_IDLE   = 2'd0;
   localparam logic [1:0] TR_BUSY   = 2'd1;
   localparam logic [1:0] TR_NONSEQ = 2'd2;
   localparam logic [1:0] TR_SEQ    = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA_A = 2'd1,
      ST_DATA_B = 2'd2
   } state_t;

   state_t state;
   state_t state_next;

   // Buffered (losing or stalled) requests, one per master
   logic              pend_a;
   logic [ADDR_W-1:0] pend_addr_a;
   logic [1:0]        pend_trans_a;
   logic              pend_write_a;
   logic [2:0]        pend_size_a;
   logic              pend_b;
   logic [ADDR_W-1:0] pend_addr_b;
   logic [1:0]        pend_trans_b;
   logic              pend_write_b;
   logic [2:0]        pend_size_b;

   // Live request decode
   logic live_a;
   logic live_b;

   // Candidate per master: buffered request takes precedence over live inputs
   logic              cand_v_a;
   logic [ADDR_W-1:0] cand_addr_a;
   logic [1:0]        cand_trans_a;
   logic              cand_write_a;
   logic [2:0]        cand_size_a;
   logic              cand_v_b;
   logic [ADDR_W-1:0] cand_addr_b;
   logic [1:0]        cand_trans_b;
   logic              cand_write_b;
   logic [2:0]        cand_size_b;

   // Burst lock owner; survives a BUSY beat from the owner so the burst can resume
   logic lock_a;
   logic lock_b;
   logic hold_a;
   logic hold_b;

   // Arbitration
   logic en_a;
   logic en_b;
   logic sel_a;
   logic sel_b;
   logic grant_a;
   logic grant_b;
   logic prio_b;

   assign live_a = HSEL_A & HTRANS_A[1];
   assign live_b = HSEL_B & HTRANS_B[1];

   assign cand_v_a     = pend_a | live_a;
   assign cand_addr_a  = pend_a ? pend_addr_a  : HADDR_A;
   assign cand_trans_a = pend_a ? pend_trans_a : HTRANS_A;
   assign cand_write_a = pend_a ? pend_write_a : HWRITE_A;
   assign cand_size_a  = pend_a ? pend_size_a  : HSIZE_A;

   assign cand_v_b     = pend_b | live_b;
   assign cand_addr_b  = pend_b ? pend_addr_b  : HADDR_B;
   assign cand_trans_b = pend_b ? pend_trans_b : HTRANS_B;
   assign cand_write_b = pend_b ? pend_write_b : HWRITE_B;
   assign cand_size_b  = pend_b ? pend_size_b  : HSIZE_B;

   // A lock owner inserting a BUSY beat keeps the other master out
   assign hold_a = lock_a & ~pend_a & HSEL_A & (HTRANS_A == TR_BUSY);
   assign hold_b = lock_b & ~pend_b & HSEL_B & (HTRANS_B == TR_BUSY);

   // Nothing is presented to the slave while reset is asserted
   assign en_a = cand_v_a & ~hold_b & rst_n;
   assign en_b = cand_v_b & ~hold_a & rst_n;

   assign grant_a = sel_a & HREADY_S;
   assign grant_b = sel_b & HREADY_S;

   assign req_wait_A = pend_a;
   assign req_wait_B = pend_b;

`ifdef AHB_REQ_RR_EN
   logic prio_q;

   // Round-robin pointer: after a NONSEQ grant the other master gets priority
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prio_q <= 1'b1;
      end else if (grant_a && (cand_trans_a == TR_NONSEQ)) begin
         prio_q <= 1'b1;
      end else if (grant_b && (cand_trans_b == TR_NONSEQ)) begin
         prio_q <= 1'b0;
      end
   end

   assign prio_b = prio_q;
`else
   assign prio_b = 1'b1;
`endif

   // Winner selection: sole requester, else burst lock, else priority pointer
   always_comb begin
      sel_a = 1'b0;
      sel_b = 1'b0;
      if (en_a && en_b) begin
         if (lock_a && (cand_trans_a == TR_SEQ)) begin
            sel_a = 1'b1;
         end else if (lock_b && (cand_trans_b == TR_SEQ)) begin
            sel_b = 1'b1;
         end else if (prio_b) begin
            sel_b = 1'b1;
         end else begin
            sel_a = 1'b1;
         end
      end else begin
         sel_a = en_a;
         sel_b = en_b;
      end
   end

   // Address-phase outputs follow the selected candidate, zero when none
   always_comb begin
      HSEL_S   = 1'b0;
      HADDR_S  = '0;
      HTRANS_S = TR_IDLE;
      HWRITE_S = 1'b0;
      HSIZE_S  = 3'd0;
      if (sel_a) begin
         HSEL_S   = 1'b1;
         HADDR_S  = cand_addr_a;
         HTRANS_S = cand_trans_a;
         HWRITE_S = cand_write_a;
         HSIZE_S  = cand_size_a;
      end else if (sel_b) begin
         HSEL_S   = 1'b1;
         HADDR_S  = cand_addr_b;
         HTRANS_S = cand_trans_b;
         HWRITE_S = cand_write_b;
         HSIZE_S  = cand_size_b;
      end
   end

   // Master A buffer: capture an ungranted live request, release once granted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_a       <= 1'b0;
         pend_addr_a  <= '0;
         pend_trans_a <= TR_IDLE;
         pend_write_a <= 1'b0;
         pend_size_a  <= 3'd0;
      end else if (pend_a) begin
         if (grant_a) begin
            pend_a <= 1'b0;
         end
      end else if (live_a && !grant_a) begin
         pend_a       <= 1'b1;
         pend_addr_a  <= HADDR_A;
         pend_trans_a <= HTRANS_A;
         pend_write_a <= HWRITE_A;
         pend_size_a  <= HSIZE_A;
      end
   end

   // Master B buffer: capture an ungranted live request, release once granted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_b       <= 1'b0;
         pend_addr_b  <= '0;
         pend_trans_b <= TR_IDLE;
         pend_write_b <= 1'b0;
         pend_size_b  <= 3'd0;
      end else if (pend_b) begin
         if (grant_b) begin
            pend_b <= 1'b0;
         end
      end else if (live_b && !grant_b) begin
         pend_b       <= 1'b1;
         pend_addr_b  <= HADDR_B;
         pend_trans_b <= HTRANS_B;
         pend_write_b <= HWRITE_B;
         pend_size_b  <= HSIZE_B;
      end
   end

   // Lock owner tracks the last accepted winner; kept across the owner's BUSY beats
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_a <= 1'b0;
         lock_b <= 1'b0;
      end else if (HREADY_S) begin
         if (sel_a || sel_b) begin
            lock_a <= sel_a;
            lock_b <= sel_b;
         end else if (!(hold_a || hold_b)) begin
            lock_a <= 1'b0;
            lock_b <= 1'b0;
         end
      end
   end

   // Data-phase state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Data-phase next state: accepted winner owns the next data phase, stall holds
   always_comb begin
      state_next = state;
      if (HREADY_S) begin
         if (sel_a) begin
            state_next = ST_DATA_A;
         end else if (sel_b) begin
            state_next = ST_DATA_B;
         end else begin
            state_next = ST_IDLE;
         end
      end
   end

   // Data-phase outputs: write-data steer and owner flag to the response mux
   always_comb begin
      arbiter_WR = 1'b0;
      HWDATA_S   = '0;
      case (state)
         ST_DATA_A: begin
            HWDATA_S = HWDATA_A;
         end
         ST_DATA_B: begin
            arbiter_WR = 1'b1;
            HWDATA_S   = HWDATA_B;
         end
         default: begin
            arbiter_WR = 1'b0;
            HWDATA_S   = '0;
         end
      endcase
   end

endmodule

// File: doc/ahb_slave_req_mux.md
# ahb_slave_req_mux

Request-side multiplexer for one shared slave port (G, T or R) in the dual-master (A/B) AHB-Lite matrix; one instance per slave. It arbitrates the two masters' address phases and buffers the losing request until it can be issued. It then steers the owner's write data in the following data phase and drives `arbiter_WR` to the response multiplexer. It is the forward-path counterpart of the HRDATA/HREADY/HRESP response mux.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, write-data width
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `HSEL_A` / `HSEL_B`  in  1  master selects this slave
- `HADDR_A` / `HADDR_B`  in  ADDR_W  address
- `HTRANS_A` / `HTRANS_B`  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
- `HWRITE_A` / `HWRITE_B`  in  1  write flag
- `HSIZE_A` / `HSIZE_B`  in  3  transfer size
- `HWDATA_A` / `HWDATA_B`  in  DATA_W  write data (data phase)
- `HREADY_S`  in  1  slave HREADYOUT
- `HSEL_S`  out  1  select to slave
- `HADDR_S`  out  ADDR_W  address to slave
- `HTRANS_S`  out  2  transfer type to slave
- `HWRITE_S`  out  1  write flag to slave
- `HSIZE_S`  out  3  size to slave
- `HWDATA_S`  out  DATA_W  write data to slave
- `arbiter_WR`  out  1  1 = B owns current data phase, 0 = A or none
- `req_wait_A` / `req_wait_B`  out  1  master's request is buffered, not yet issued

## Operation
- Live request valid: `HSEL_x & HTRANS_x[1]`. The candidate for master x is its pending buffer if `pend_x` is set, else its live request. While `pend_x` is set, live inputs of x are ignored.
- Grant is combinational, evaluated only when `HREADY_S`=1:
  - only one candidate valid: that master wins;
  - both valid: burst lock first, then priority;
  - burst lock: if the candidate of the current data-phase owner is SEQ, the owner wins.
- Winner's address/control drive `HSEL_S`=1, `HADDR_S`, `HTRANS_S`, `HWRITE_S`, `HSIZE_S`. With no winner: `HSEL_S`=0, `HTRANS_S`=0, other fields 0.
- Pending capture at clock edge: a valid live candidate that is not granted (lost arbitration, or `HREADY_S`=0) is stored into `pend_x` with its full control. A granted pending buffer is cleared.
- `req_wait_x` = `pend_x` (registered).
- Data-phase FSM: states IDLE, DATA_A, DATA_B.
  - When `HREADY_S`=1, the next state is DATA_<winner>, or IDLE if there is no winner.
  - When `HREADY_S`=0, the state holds.
- `arbiter_WR` = (state == DATA_B).
- `HWDATA_S` = `HWDATA_A` in DATA_A, `HWDATA_B` in DATA_B, 0 in IDLE.
- Reset (async, any time, including mid-burst or with pending set):
  - state IDLE, both pend cleared, priority pointer = B;
  - all outputs 0, `HTRANS_S`=IDLE, `arbiter_WR`=0, `req_wait_*`=0;
  - dropped pending requests are not replayed.

## Timing
- Uncontested request with `HREADY_S`=1: on `HADDR_S` in the same cycle. Data-phase owner and `HWDATA_S` follow in the next cycle.
- Loser: `req_wait` rises the next cycle. Earliest issue is the cycle after the winner's address phase, if `HREADY_S`=1.
- `HREADY_S`=0: address outputs still show the candidate selection, but nothing is accepted. State, `HWDATA_S` owner and `arbiter_WR` are held.
- Both masters requesting while the slave is stalled: both are captured if not already pending. Arbitration resolves when `HREADY_S` returns high.
- A BUSY/IDLE transfer type is never granted or buffered. A BUSY inside a locked burst does not release the lock.

## Configuration
- `AHB_REQ_RR_EN` defined: round-robin. The priority pointer moves to the non-winner after every NONSEQ grant; SEQ grants do not move it.
- `AHB_REQ_RR_EN` undefined: fixed priority, B over A (pointer constant B). Burst lock still applies.

## Test plan
- Reset mid-burst with `pend_A`=1: `rst_n` low -> `HSEL_S`=0, `HTRANS_S`=0, `arbiter_WR`=0, `req_wait_A`=0 immediately. After release, nothing is issued until a new request.
- A alone, NONSEQ write to 0x100, data 0xDEADBEEF, `HREADY_S`=1 -> `HADDR_S`=0x100 that cycle. Next cycle `HWDATA_S`=0xDEADBEEF and `arbiter_WR`=0.
- A and B NONSEQ same cycle (A 0x10, B 0x20), fixed priority -> `HADDR_S`=0x20, then `req_wait_A`=1. Next cycle `HADDR_S`=0x10 and `arbiter_WR`=1. The cycle after, `req_wait_A`=0 and `arbiter_WR`=0.
- `AHB_REQ_RR_EN`, three back-to-back conflicts -> grants B, A, B.
- B SEQ burst (4 beats) while A requests NONSEQ -> all 4 B beats issue contiguously. `req_wait_A` stays 1 until A issues on the 5th cycle.
- `HREADY_S` held 0 for 3 cycles in DATA_A with B requesting -> `arbiter_WR`=0 and `HWDATA_S`=`HWDATA_A` held; `req_wait_B`=1. B issues when `HREADY_S`=1.
